// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source for the DVI transmitter path.
// Outputs are a registered decode of the pre-edge (h_cnt, v_cnt) position.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] bar_sub;
  logic [2:0]    bar_idx;
  logic [1:0]    pat;

  logic          de_c, hs_on_c, vs_on_c, fs_c, h_last_c, v_last_c;
  logic [23:0]   bar_rgb_c, pix_c;

  // Position decode of the pre-edge counters
  always_comb begin
    h_last_c = (h_cnt == H_LAST);
    v_last_c = (v_cnt == V_LAST);
    de_c     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_on_c  = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
    vs_on_c  = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
    fs_c     = (h_cnt == '0) && (v_cnt == '0);
  end

  // Colour-bar lookup indexed by the bar counter
  always_comb begin
    bar_rgb_c = 24'h000000;
    case (bar_idx)
      3'd0:    bar_rgb_c = 24'hFFFFFF;
      3'd1:    bar_rgb_c = 24'hFFFF00;
      3'd2:    bar_rgb_c = 24'h00FFFF;
      3'd3:    bar_rgb_c = 24'h00FF00;
      3'd4:    bar_rgb_c = 24'hFF00FF;
      3'd5:    bar_rgb_c = 24'hFF0000;
      3'd6:    bar_rgb_c = 24'h0000FF;
      default: bar_rgb_c = 24'h000000;
    endcase
  end

  // Pattern mux; blanking forces black
  always_comb begin
    pix_c = 24'h000000;
    if (de_c) begin
      case (pat)
        2'd0:    pix_c = bar_rgb_c;
        2'd1:    pix_c = {3{h_cnt[7:0]}};
        2'd2:    pix_c = (h_cnt[3] ^ v_cnt[3]) ? 24'hFFFFFF : 24'h000000;
        default: pix_c = solid_rgb;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_sub     <= '0;
      bar_idx     <= '0;
      pat         <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      rgb         <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      de          <= de_c;
      hsync       <= hs_on_c ? HS_POL : ~HS_POL;
      vsync       <= vs_on_c ? VS_POL : ~VS_POL;
      rgb         <= pix_c;
      x           <= h_cnt;
      y           <= v_cnt;
      frame_start <= fs_c;
      if (h_last_c) begin
        h_cnt   <= '0;
        bar_sub <= '0;
        bar_idx <= '0;
        v_cnt   <= v_last_c ? '0 : v_cnt + CW'(1);
        // New pattern only takes hold at the frame boundary
        if (v_last_c) pat <= pattern_sel;
      end else begin
        h_cnt <= h_cnt + CW'(1);
        if (bar_sub == BAR_LAST) begin
          bar_sub <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_sub <= bar_sub + CW'(1);
        end
      end
    end
  end

endmodule
